// File: rtl/sort_seq_pkg.sv
// Shared types and constants for the sort sequencer.
package sort_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SWAP_CNT_W = 8;

  // Saturating increment for the swap statistics counter.
  function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
    logic [SWAP_CNT_W-1:0] r;
    if (v == {SWAP_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(SWAP_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sort_compare_swap.sv
// Combinational compare/swap of one adjacent pair.
// lo is the value destined for the lower index, hi for the upper index.
module sort_compare_swap #(
  parameter int WIDTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  // Strict compare so equal values stay put and the sort remains stable.
  always_comb begin
    swap = 1'b0;
    if (DESCEND) begin
      swap = (a < b);
    end else begin
      swap = (a > b);
    end
    if (swap) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/sort_sequencer.sv
// Batch bubble-sort sequencer: load DEPTH words, sort with one shared comparator, drain.
// Optional macro SORT_STATS_EN adds the swap_cnt statistics port.
module sort_sequencer
  import sort_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy
`ifdef SORT_STATS_EN
  ,
  output logic [SWAP_CNT_W-1:0] swap_cnt
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PAIR = IW'(DEPTH - 2);
  localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] mem_s [DEPTH];
  logic [IW-1:0]    wr_idx_r, wr_idx_s;
  logic [IW-1:0]    cmp_idx_r, cmp_idx_s;
  logic [IW-1:0]    rd_idx_r, rd_idx_s;
  logic [PW-1:0]    pass_cnt_r, pass_cnt_s;
  logic             pass_swap_r, pass_swap_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic             busy_r, busy_s;
  logic [WIDTH-1:0] out_data_r, out_data_s;

  logic [IW-1:0]    cmp_b_idx_s;
  logic [IW-1:0]    rd_nxt_s;
  logic [WIDTH-1:0] cmp_a_s, cmp_b_s, cmp_lo_s, cmp_hi_s;
  logic             cmp_swap_s;
  logic             in_fire_s, out_fire_s;

  assign cmp_b_idx_s = cmp_idx_r + 1'b1;
  assign rd_nxt_s    = rd_idx_r + 1'b1;
  assign cmp_a_s     = mem_r[cmp_idx_r];
  assign cmp_b_s     = mem_r[cmp_b_idx_s];
  assign in_fire_s   = in_valid && in_ready_r && (state_r == LOAD);
  assign out_fire_s  = out_valid_r && out_ready && (state_r == DRAIN);

  sort_compare_swap #(
    .WIDTH   (WIDTH),
    .DESCEND (DESCEND)
  ) u_cmp (
    .a    (cmp_a_s),
    .b    (cmp_b_s),
    .lo   (cmp_lo_s),
    .hi   (cmp_hi_s),
    .swap (cmp_swap_s)
  );

  // Next-state, storage update and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    wr_idx_s    = wr_idx_r;
    cmp_idx_s   = cmp_idx_r;
    rd_idx_s    = rd_idx_r;
    pass_cnt_s  = pass_cnt_r;
    pass_swap_s = pass_swap_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    for (int k = 0; k < DEPTH; k++) begin
      mem_s[k] = mem_r[k];
    end

    case (state_r)
      LOAD: begin
        in_ready_s = 1'b1;
        if (in_fire_s) begin
          mem_s[wr_idx_r] = in_data;
          if (wr_idx_r == LAST_IDX) begin
            state_s     = SORT;
            in_ready_s  = 1'b0;
            wr_idx_s    = '0;
            cmp_idx_s   = '0;
            pass_cnt_s  = '0;
            pass_swap_s = 1'b0;
          end else begin
            wr_idx_s = wr_idx_r + 1'b1;
          end
        end else begin
          wr_idx_s = wr_idx_r;
        end
      end
      SORT: begin
        mem_s[cmp_idx_r]   = cmp_lo_s;
        mem_s[cmp_b_idx_s] = cmp_hi_s;
        if (cmp_idx_r == LAST_PAIR) begin
          // A clean pass means sorted; DEPTH-1 passes is the worst case.
          if (!(pass_swap_r || cmp_swap_s) || (pass_cnt_r == LAST_PASS)) begin
            state_s     = DRAIN;
            out_valid_s = 1'b1;
            rd_idx_s    = '0;
            cmp_idx_s   = '0;
            pass_cnt_s  = '0;
            pass_swap_s = 1'b0;
            out_data_s  = mem_s[0];
          end else begin
            cmp_idx_s   = '0;
            pass_cnt_s  = pass_cnt_r + 1'b1;
            pass_swap_s = 1'b0;
          end
        end else begin
          cmp_idx_s   = cmp_b_idx_s;
          pass_swap_s = pass_swap_r || cmp_swap_s;
        end
      end
      DRAIN: begin
        if (out_fire_s) begin
          if (rd_idx_r == LAST_IDX) begin
            state_s     = LOAD;
            out_valid_s = 1'b0;
            in_ready_s  = 1'b1;
            rd_idx_s    = '0;
          end else begin
            rd_idx_s   = rd_nxt_s;
            out_data_s = mem_r[rd_nxt_s];
          end
        end else begin
          rd_idx_s = rd_idx_r;
        end
      end
      default: begin
        state_s     = LOAD;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        wr_idx_s    = '0;
        cmp_idx_s   = '0;
        rd_idx_s    = '0;
        pass_cnt_s  = '0;
        pass_swap_s = 1'b0;
      end
    endcase

    busy_s = (state_s == SORT) || (state_s == DRAIN);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      wr_idx_r    <= '0;
      cmp_idx_r   <= '0;
      rd_idx_r    <= '0;
      pass_cnt_r  <= '0;
      pass_swap_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      wr_idx_r    <= wr_idx_s;
      cmp_idx_r   <= cmp_idx_s;
      rd_idx_r    <= rd_idx_s;
      pass_cnt_r  <= pass_cnt_s;
      pass_swap_r <= pass_swap_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      out_data_r  <= out_data_s;
    end
  end

  // Batch storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_r[k] <= mem_s[k];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

`ifdef SORT_STATS_EN
  logic [SWAP_CNT_W-1:0] swap_cnt_r;
  logic                  swap_clr_s, swap_inc_s;

  assign swap_clr_s = in_fire_s && (wr_idx_r == LAST_IDX);
  assign swap_inc_s = (state_r == SORT) && cmp_swap_s;

  // Swap statistics: cleared on entering SORT, held until the next sort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_cnt_r <= '0;
    end else if (swap_clr_s) begin
      swap_cnt_r <= '0;
    end else if (swap_inc_s) begin
      swap_cnt_r <= sat_inc(swap_cnt_r);
    end else begin
      swap_cnt_r <= swap_cnt_r;
    end
  end

  assign swap_cnt = swap_cnt_r;
`endif

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer: vector table, scoreboard queues, corner sequences.
module tb_sort_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic       d_en;
  logic       in_valid_d;
  logic       in_ready_d;
  logic       out_valid_d;
  logic       out_ready_d;
  logic [3:0] out_data_d;
  logic       busy_d;
`ifdef SORT_STATS_EN
  logic [7:0] swap_cnt;
  logic [7:0] swap_cnt_d;
`endif

  assign in_valid_d  = in_valid && d_en;
  assign out_ready_d = 1'b1;

  always #5 clk = ~clk;

  sort_sequencer #(.WIDTH(4), .DEPTH(4), .DESCEND(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SORT_STATS_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  sort_sequencer #(.WIDTH(4), .DEPTH(4), .DESCEND(1'b1)) dut_d (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_d),
    .in_ready  (in_ready_d),
    .in_data   (in_data),
    .out_valid (out_valid_d),
    .out_ready (out_ready_d),
    .out_data  (out_data_d),
    .busy      (busy_d)
`ifdef SORT_STATS_EN
    ,
    .swap_cnt  (swap_cnt_d)
`endif
  );

  typedef struct {
    logic [3:0][3:0] w;
    logic [3:0][3:0] e;
    int              swaps;
    int              cyc;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   sort_cyc = 0;
  int   sort_cyc_d = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_qd[$];
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, e0, e1, e2, e3, s, c);
    vec_t v;
    v.w[0] = 4'(a0); v.w[1] = 4'(a1); v.w[2] = 4'(a2); v.w[3] = 4'(a3);
    v.e[0] = 4'(e0); v.e[1] = 4'(e1); v.e[2] = 4'(e2); v.e[3] = 4'(e3);
    v.swaps = s;
    v.cyc   = c;
    return v;
  endfunction

  // Output scoreboards: compare each accepted word against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
      if (out_valid_d) begin
        if (exp_qd.size() == 0) begin
          check("unexpected_out_desc", 1, 0);
        end else begin
          check("out_data_desc", int'(out_data_d), int'(exp_qd.pop_front()));
        end
      end
      if (busy && !out_valid) sort_cyc++;
      if (busy_d && !out_valid_d) sort_cyc_d++;
    end
  end

  task automatic push_exp(input logic [3:0][3:0] e);
    for (int k = 0; k < 4; k++) exp_q.push_back(e[k]);
  endtask

  task automatic load4(input logic [3:0][3:0] w, input bit rnd);
    int  n = 0;
    int  g = 0;
    bit  v;
    @(posedge clk); #1;
    while (n < 4 && g < 100) begin
      g++;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? w[n] : 4'($urandom_range(0, 15));
      @(negedge clk);
      check("load_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      if (v) n++;
    end
    in_valid = 1'b0;
    if (n < 4) check("load_timeout", n, 4);
    @(negedge clk);
    check("sort_in_ready", int'(in_ready), 0);
    check("sort_busy", int'(busy), 1);
  endtask

  task automatic wait_done(input bit spam);
    int g = 0;
    while (g < 200) begin
      g++;
      @(negedge clk);
      if (spam) check("drain_in_ready", int'(in_ready), 0);
      @(posedge clk);
      if (exp_q.size() == 0 && exp_qd.size() == 0) break;
      #1;
      if (spam) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 15));
      end
    end
    if (g >= 200) check("drain_timeout", g, 0);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("done_out_valid", int'(out_valid), 0);
    check("done_busy", int'(busy), 0);
    check("done_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][3:0] w;
    logic [3:0][3:0] e;
    logic [3:0]      t;
    int              inv;
    int              g;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1; d_en = 1'b0;
    vecs[0] = mk(3, 1, 2, 0,   0, 1, 2, 3,   5, 9);
    vecs[1] = mk(1, 2, 3, 4,   1, 2, 3, 4,   0, 3);
    vecs[2] = mk(0, 0, 0, 0,   0, 0, 0, 0,   0, 3);
    vecs[3] = mk(5, 4, 6, 1,   1, 4, 5, 6,   4, 9);
    vecs[4] = mk(2, 1, 3, 4,   1, 2, 3, 4,   1, 6);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      sort_cyc = 0;
      push_exp(vecs[i].e);
      load4(vecs[i].w, 1'b0);
      wait_done(1'b0);
      check("sort_cycles", sort_cyc, vecs[i].cyc);
`ifdef SORT_STATS_EN
      check("swap_cnt", int'(swap_cnt), vecs[i].swaps);
`endif
    end

    // Worst-case input on both orders at once.
    w = {4'd0, 4'd5, 4'd10, 4'd15};
    e = {4'd15, 4'd10, 4'd5, 4'd0};
    push_exp(e);
    for (int k = 0; k < 4; k++) exp_qd.push_back(w[k]);
    sort_cyc = 0; sort_cyc_d = 0; d_en = 1'b1;
    load4(w, 1'b0);
    d_en = 1'b0;
    wait_done(1'b0);
    check("sort_cycles_rev", sort_cyc, 9);
    check("sort_cycles_desc", sort_cyc_d, 3);
`ifdef SORT_STATS_EN
    check("swap_cnt_rev", int'(swap_cnt), 6);
    check("swap_cnt_desc", int'(swap_cnt_d), 0);
`endif

    // Consumer back-pressure at the head of DRAIN.
    out_ready = 1'b0;
    w = {4'd7, 4'd2, 4'd7, 4'd7};
    e = {4'd7, 4'd7, 4'd7, 4'd2};
    push_exp(e);
    load4(w, 1'b0);
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("stall_reached_drain", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_data", int'(out_data), 2);
      check("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(1'b0);
`ifdef SORT_STATS_EN
    check("swap_cnt_dup", int'(swap_cnt), 2);
`endif

    // Reset in the middle of the second sort pass.
    w = {4'd0, 4'd5, 4'd10, 4'd15};
    load4(w, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
`ifdef SORT_STATS_EN
    check("midrst_swap_cnt", int'(swap_cnt), 0);
`endif
    @(negedge clk);
    check("midrst_in_ready_up", int'(in_ready), 1);
    w = {4'd6, 4'd7, 4'd8, 4'd9};
    e = {4'd9, 4'd8, 4'd7, 4'd6};
    push_exp(e);
    load4(w, 1'b0);
    wait_done(1'b0);

    // Random valid gaps during LOAD, producer pushing during DRAIN.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) w[k] = 4'($urandom_range(0, 15));
      inv = 0;
      for (int a = 0; a < 4; a++)
        for (int c = a + 1; c < 4; c++)
          if (w[a] > w[c]) inv++;
      e = w;
      for (int a = 1; a < 4; a++)
        for (int c = a; c > 0; c--)
          if (e[c-1] > e[c]) begin
            t = e[c]; e[c] = e[c-1]; e[c-1] = t;
          end
      push_exp(e);
      load4(w, 1'b1);
      wait_done(1'b1);
`ifdef SORT_STATS_EN
      check("swap_cnt_rand", int'(swap_cnt), inv);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
